// File: rtl/wb_gpr_arb_if.sv
// Write-back bus between the execution units (MUL, DIV, LSU, ALU), the arbiter,
// and the GPR write port / OITF retire / control stall.
interface wb_gpr_arb_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned AW   = 5
);
    logic            mul_wb_vld;
    logic [AW-1:0]   mul_wb_rd;
    logic [XLEN-1:0] mul_wb_wdata;
    logic            mul_wb_wen;
    logic            mul_wb_rdy;

    logic            div_wb_vld;
    logic [AW-1:0]   div_wb_rd;
    logic [XLEN-1:0] div_wb_wdata;
    logic            div_wb_wen;
    logic            div_wb_rdy;

    logic            lsu_wb_vld;
    logic [AW-1:0]   lsu_wb_rd;
    logic [XLEN-1:0] lsu_wb_wdata;
    logic            lsu_wb_wen;
    logic            lsu_wb_rdy;

    logic            alu_wb_vld;
    logic [AW-1:0]   alu_wb_rd;
    logic [XLEN-1:0] alu_wb_wdata;
    logic            alu_wb_wen;
    logic            alu_wb_rdy;

    logic            wb_gpr_ena;
    logic [AW-1:0]   wb_gpr_waddr;
    logic [XLEN-1:0] wb_gpr_wdata;
    logic [3:0]      wb_oitf_grant;
    logic            wb_ctrl_alu_stall;

    modport master (
        output mul_wb_vld, mul_wb_rd, mul_wb_wdata, mul_wb_wen,
        output div_wb_vld, div_wb_rd, div_wb_wdata, div_wb_wen,
        output lsu_wb_vld, lsu_wb_rd, lsu_wb_wdata, lsu_wb_wen,
        output alu_wb_vld, alu_wb_rd, alu_wb_wdata, alu_wb_wen,
        input  mul_wb_rdy, div_wb_rdy, lsu_wb_rdy, alu_wb_rdy,
        input  wb_gpr_ena, wb_gpr_waddr, wb_gpr_wdata, wb_oitf_grant, wb_ctrl_alu_stall
    );

    modport slave (
        input  mul_wb_vld, mul_wb_rd, mul_wb_wdata, mul_wb_wen,
        input  div_wb_vld, div_wb_rd, div_wb_wdata, div_wb_wen,
        input  lsu_wb_vld, lsu_wb_rd, lsu_wb_wdata, lsu_wb_wen,
        input  alu_wb_vld, alu_wb_rd, alu_wb_wdata, alu_wb_wen,
        output mul_wb_rdy, div_wb_rdy, lsu_wb_rdy, alu_wb_rdy,
        output wb_gpr_ena, wb_gpr_waddr, wb_gpr_wdata, wb_oitf_grant, wb_ctrl_alu_stall
    );
endinterface

// File: rtl/wb_gpr_arb.sv
// Write-back arbiter: one hold buffer per unit, fixed priority with age-based override.
// Define WB_BYPASS_EN to let an empty source's incoming result win arbitration in the same cycle.
module wb_gpr_arb #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_gpr_arb_if.slave  wb
);
    localparam int unsigned NSRC = 4;
    localparam int unsigned AGEW = $clog2(STARVE_MAX + 1);
    localparam logic [AGEW-1:0] AGE_MAX = AGEW'(STARVE_MAX);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wdata;
        logic            wen;
    } wb_ent_t;

    logic [NSRC-1:0] src_vld;
    wb_ent_t         src_ent [NSRC];

    logic [NSRC-1:0] full_q, full_d;
    wb_ent_t         ent_q [NSRC];
    wb_ent_t         ent_d [NSRC];
    logic [AGEW-1:0] age_q [NSRC];
    logic [AGEW-1:0] age_d [NSRC];

    logic [NSRC-1:0] cand_c, starve_c, gnt_c, rdy_c, byp_gnt_c, acc_c;
    wb_ent_t         sel_c;

    // Source index 0..3 = MUL, DIV, LSU, ALU
    assign src_vld    = {wb.alu_wb_vld, wb.lsu_wb_vld, wb.div_wb_vld, wb.mul_wb_vld};
    assign src_ent[0] = '{rd: wb.mul_wb_rd, wdata: wb.mul_wb_wdata, wen: wb.mul_wb_wen};
    assign src_ent[1] = '{rd: wb.div_wb_rd, wdata: wb.div_wb_wdata, wen: wb.div_wb_wen};
    assign src_ent[2] = '{rd: wb.lsu_wb_rd, wdata: wb.lsu_wb_wdata, wen: wb.lsu_wb_wen};
    assign src_ent[3] = '{rd: wb.alu_wb_rd, wdata: wb.alu_wb_wdata, wen: wb.alu_wb_wen};

    // Candidate selection: starving entries first, then fixed priority
    always_comb begin
        cand_c   = full_q;
`ifdef WB_BYPASS_EN
        cand_c   = full_q | src_vld;
`endif
        starve_c = '0;
        gnt_c    = '0;
        for (int i = 0; i < NSRC; i++) begin
            starve_c[i] = full_q[i] && (age_q[i] == AGE_MAX);
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (|starve_c) begin
                if (starve_c[i]) begin
                    gnt_c    = '0;
                    gnt_c[i] = 1'b1;
                end
            end else if (cand_c[i]) begin
                gnt_c    = '0;
                gnt_c[i] = 1'b1;
            end
        end
    end

    // Granted payload (buffer, or live input when bypassed); zero when idle
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_c[i]) begin
                sel_c = full_q[i] ? ent_q[i] : src_ent[i];
            end
        end
    end

    // Buffer next state: load on accept unless consumed by bypass, clear on grant
    always_comb begin
        rdy_c     = ~full_q | gnt_c;
        byp_gnt_c = gnt_c & ~full_q;
        acc_c     = src_vld & rdy_c & ~byp_gnt_c;
        for (int i = 0; i < NSRC; i++) begin
            full_d[i] = acc_c[i] | (full_q[i] & ~gnt_c[i]);
            ent_d[i]  = acc_c[i] ? src_ent[i] : ent_q[i];
            age_d[i]  = '0;
            if (!acc_c[i] && full_q[i] && !gnt_c[i]) begin
                age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGEW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < NSRC; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign wb.mul_wb_rdy        = rdy_c[0];
    assign wb.div_wb_rdy        = rdy_c[1];
    assign wb.lsu_wb_rdy        = rdy_c[2];
    assign wb.alu_wb_rdy        = rdy_c[3];
    assign wb.wb_oitf_grant     = gnt_c;
    assign wb.wb_gpr_ena        = (|gnt_c) & sel_c.wen & (sel_c.rd != '0);
    assign wb.wb_gpr_waddr      = sel_c.rd;
    assign wb.wb_gpr_wdata      = sel_c.wdata;
    assign wb.wb_ctrl_alu_stall = full_q[3] & ~gnt_c[3];

endmodule

// File: tb/tb_wb_gpr_arb.sv
// Bench for wb_gpr_arb: directed literal scenarios plus randomized traffic against an
// age-by-timestamp reference model checked every cycle.
module tb_wb_gpr_arb;
    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;
    localparam int unsigned SM   = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_gpr_arb_if #(.XLEN(XLEN), .AW(AW)) bus ();

    wb_gpr_arb #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    logic [3:0]      vld;
    logic [AW-1:0]   rd  [4];
    logic [XLEN-1:0] wd  [4];
    logic [3:0]      wen;

    assign bus.mul_wb_vld = vld[0];  assign bus.mul_wb_rd = rd[0];  assign bus.mul_wb_wdata = wd[0];  assign bus.mul_wb_wen = wen[0];
    assign bus.div_wb_vld = vld[1];  assign bus.div_wb_rd = rd[1];  assign bus.div_wb_wdata = wd[1];  assign bus.div_wb_wen = wen[1];
    assign bus.lsu_wb_vld = vld[2];  assign bus.lsu_wb_rd = rd[2];  assign bus.lsu_wb_wdata = wd[2];  assign bus.lsu_wb_wen = wen[2];
    assign bus.alu_wb_vld = vld[3];  assign bus.alu_wb_rd = rd[3];  assign bus.alu_wb_wdata = wd[3];  assign bus.alu_wb_wen = wen[3];

    wire [3:0] rdy_o = {bus.alu_wb_rdy, bus.lsu_wb_rdy, bus.div_wb_rdy, bus.mul_wb_rdy};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model: each held entry remembers the cycle it became visible
    bit              m_full [4];
    logic [AW-1:0]   m_rd   [4];
    logic [XLEN-1:0] m_wd   [4];
    bit              m_wen  [4];
    int              m_lc   [4];
    int              cyc = 0;
    int              g;
    logic [3:0]      e_gnt, e_rdy;
    logic [AW-1:0]   e_rd;
    logic [XLEN-1:0] e_wd;
    bit              e_wen, e_ena, e_stall, acc;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
            check("rst_grant", 64'(bus.wb_oitf_grant), 64'd0);
            check("rst_ena",   64'(bus.wb_gpr_ena),    64'd0);
            check("rst_waddr", 64'(bus.wb_gpr_waddr),  64'd0);
            check("rst_wdata", bus.wb_gpr_wdata,       64'd0);
            check("rst_rdy",   64'(rdy_o),             64'hf);
            check("rst_stall", 64'(bus.wb_ctrl_alu_stall), 64'd0);
        end else begin
            g = -1;
            for (int i = 0; i < 4; i++)
                if (g < 0 && m_full[i] && (cyc - m_lc[i]) >= int'(SM)) g = i;
            for (int i = 0; i < 4; i++)
                if (g < 0 && (m_full[i] || (BYP && vld[i]))) g = i;
            e_gnt = '0; e_rd = '0; e_wd = '0; e_wen = 1'b0;
            if (g >= 0) begin
                e_gnt[g] = 1'b1;
                e_rd  = m_full[g] ? m_rd[g]  : rd[g];
                e_wd  = m_full[g] ? m_wd[g]  : wd[g];
                e_wen = m_full[g] ? m_wen[g] : wen[g];
            end
            e_ena   = (g >= 0) && e_wen && (e_rd != 0);
            for (int i = 0; i < 4; i++) e_rdy[i] = !m_full[i] || (g == i);
            e_stall = m_full[3] && (g != 3);
            check("grant", 64'(bus.wb_oitf_grant), 64'(e_gnt));
            check("ena",   64'(bus.wb_gpr_ena),    64'(e_ena));
            check("waddr", 64'(bus.wb_gpr_waddr),  64'(e_rd));
            check("wdata", bus.wb_gpr_wdata,       e_wd);
            check("rdy",   64'(rdy_o),             64'(e_rdy));
            check("stall", 64'(bus.wb_ctrl_alu_stall), 64'(e_stall));
            for (int i = 0; i < 4; i++) begin
                acc = vld[i] && e_rdy[i] && !((g == i) && !m_full[i]);
                if (acc) begin
                    m_full[i] = 1'b1;
                    m_rd[i]   = rd[i];
                    m_wd[i]   = wd[i];
                    m_wen[i]  = wen[i];
                    m_lc[i]   = cyc + 1;
                end else if (g == i) begin
                    m_full[i] = 1'b0;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [AW-1:0] r, input logic [XLEN-1:0] d, input bit w);
        vld[s] = 1'b1;
        rd[s]  = r;
        wd[s]  = d;
        wen[s] = w;
    endtask

    task automatic idle();
        vld = '0;
    endtask

    initial begin
        rst = 1'b1;
        vld = '0;
        wen = '0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = '0;
            wd[i] = '0;
        end
        step();
        step();
        rst = 1'b0;
        step();

`ifndef WB_BYPASS_EN
        // Single ALU write, one-cycle latency
        drive(3, 5'd5, 64'h1234, 1'b1);
        settle();
        check("t1_pre_grant", 64'(bus.wb_oitf_grant), 64'd0);
        check("t1_alu_rdy",   64'(rdy_o[3]), 64'd1);
        step(); idle(); settle();
        check("t1_grant", 64'(bus.wb_oitf_grant), 64'b1000);
        check("t1_ena",   64'(bus.wb_gpr_ena), 64'd1);
        check("t1_waddr", 64'(bus.wb_gpr_waddr), 64'd5);
        check("t1_wdata", bus.wb_gpr_wdata, 64'h1234);
        step(); settle();
        check("t1_idle", 64'(bus.wb_oitf_grant), 64'd0);
        step();

        // Fixed priority: MUL before ALU
        drive(0, 5'd1, 64'h11, 1'b1);
        drive(3, 5'd2, 64'h22, 1'b1);
        step(); idle(); settle();
        check("t2_grant_mul", 64'(bus.wb_oitf_grant), 64'b0001);
        check("t2_waddr_mul", 64'(bus.wb_gpr_waddr), 64'd1);
        check("t2_stall",     64'(bus.wb_ctrl_alu_stall), 64'd1);
        check("t2_alu_rdy",   64'(rdy_o[3]), 64'd0);
        step(); settle();
        check("t2_grant_alu", 64'(bus.wb_oitf_grant), 64'b1000);
        check("t2_waddr_alu", 64'(bus.wb_gpr_waddr), 64'd2);
        check("t2_stall_off", 64'(bus.wb_ctrl_alu_stall), 64'd0);
        step();

        // Starvation: ALU wins in its 5th held cycle against continuous MUL
        drive(0, 5'd4, 64'h40, 1'b1);
        drive(3, 5'd3, 64'h33, 1'b1);
        step();
        vld[3] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            settle();
            if (k == 5) begin
                check("t3_grant_alu", 64'(bus.wb_oitf_grant), 64'b1000);
                check("t3_mul_rdy",   64'(rdy_o[0]), 64'd0);
            end else begin
                check("t3_grant_mul", 64'(bus.wb_oitf_grant), 64'b0001);
            end
            step();
            wd[0] = wd[0] + 64'd1;
        end
        idle();
        step(); step(); step();

        // x0 write and commit-only
        drive(2, 5'd0, 64'hBEEF, 1'b1);
        drive(1, 5'd7, 64'h77, 1'b0);
        step(); idle(); settle();
        check("t4_grant_div", 64'(bus.wb_oitf_grant), 64'b0010);
        check("t4_ena_div",   64'(bus.wb_gpr_ena), 64'd0);
        check("t4_waddr_div", 64'(bus.wb_gpr_waddr), 64'd7);
        step(); settle();
        check("t4_grant_lsu", 64'(bus.wb_oitf_grant), 64'b0100);
        check("t4_ena_lsu",   64'(bus.wb_gpr_ena), 64'd0);
        step();

        // Grant and reload in the same cycle
        drive(1, 5'd8, 64'h55, 1'b1);
        step();
        drive(1, 5'd9, 64'hAA, 1'b1);
        settle();
        check("t5_grant_old", 64'(bus.wb_oitf_grant), 64'b0010);
        check("t5_waddr_old", 64'(bus.wb_gpr_waddr), 64'd8);
        check("t5_div_rdy",   64'(rdy_o[1]), 64'd1);
        step(); idle(); settle();
        check("t5_grant_new", 64'(bus.wb_oitf_grant), 64'b0010);
        check("t5_waddr_new", 64'(bus.wb_gpr_waddr), 64'd9);
        check("t5_wdata_new", bus.wb_gpr_wdata, 64'hAA);
        check("t5_ena_new",   64'(bus.wb_gpr_ena), 64'd1);
        step(); settle();
        check("t5_idle", 64'(bus.wb_oitf_grant), 64'd0);
        step();

        // Reset with three entries in flight
        drive(0, 5'd1, 64'd1, 1'b1);
        drive(1, 5'd2, 64'd2, 1'b1);
        drive(2, 5'd3, 64'd3, 1'b1);
        step(); idle(); settle();
        check("t6_grant_pre", 64'(bus.wb_oitf_grant), 64'b0001);
        step();
        rst = 1'b1;
        #1;
        check("t6_grant_rst", 64'(bus.wb_oitf_grant), 64'd0);
        check("t6_ena_rst",   64'(bus.wb_gpr_ena), 64'd0);
        check("t6_rdy_rst",   64'(rdy_o), 64'hf);
        step();
        rst = 1'b0;
        settle();
        check("t6_no_stale",  64'(bus.wb_oitf_grant), 64'd0);
        check("t6_no_write",  64'(bus.wb_gpr_ena), 64'd0);
        step(); settle();
        check("t6_still_idle", 64'(bus.wb_oitf_grant), 64'd0);
        step();
`endif

        // Randomized traffic; MUL biased busy to exercise the starvation override
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                vld[i] = ($urandom_range(99) < ((i == 0) ? 85 : 40));
                rd[i]  = ($urandom_range(3) == 0) ? '0 : AW'($urandom);
                wd[i]  = {$urandom, $urandom};
                wen[i] = ($urandom_range(3) != 0);
            end
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        for (int n = 0; n < 12; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
